// File: rtl/vx_mem_port_arbiter.sv
// Shares one external memory port among NUM_REQS requesters with round-robin arbitration.
// The winner index rides in the tag LSBs so responses route back without any lookup table.
module vx_mem_port_arbiter #(
   parameter int unsigned NUM_REQS     = 4,
   parameter int unsigned ADDR_WIDTH   = 26,
   parameter int unsigned DATA_WIDTH   = 512,
   parameter int unsigned TAG_IN_WIDTH = 8,
   parameter int unsigned MAX_PENDING  = 16,
   localparam int unsigned SEL_W         = $clog2(NUM_REQS),
   localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_W,
   localparam int unsigned BYTEEN_W      = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             reset,

   input  logic [NUM_REQS-1:0]              in_req_valid,
   input  logic [NUM_REQS-1:0]              in_req_rw,
   input  logic [NUM_REQS*BYTEEN_W-1:0]     in_req_byteen,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
   input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
   output logic [NUM_REQS-1:0]              in_req_ready,

   output logic [NUM_REQS-1:0]              in_rsp_valid,
   output logic [DATA_WIDTH-1:0]            in_rsp_data,
   output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag,
   input  logic [NUM_REQS-1:0]              in_rsp_ready,

   output logic                             mem_req_valid,
   output logic                             mem_req_rw,
   output logic [BYTEEN_W-1:0]              mem_req_byteen,
   output logic [ADDR_WIDTH-1:0]            mem_req_addr,
   output logic [DATA_WIDTH-1:0]            mem_req_data,
   output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
   input  logic                             mem_req_ready,

   input  logic                             mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
   input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
   output logic                             mem_rsp_ready,

   output logic                             busy,
   output logic                             rsp_err
);

   localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

   logic [NUM_REQS-1:0]     eligible;
   logic [NUM_REQS-1:0]     rotated;
   logic [NUM_REQS-1:0]     grant;
   logic [NUM_REQS-1:0]     rsp_fire;
   logic [SEL_W-1:0]        ptr_q, ptr_d;
   logic [SEL_W-1:0]        winner;
   logic [SEL_W-1:0]        rsp_sel;
   logic                    grant_found;
   logic                    stage_ready;
   logic                    accept;
   logic                    rsp_sel_ok;
   logic                    any_pending;
   logic                    cnt_zero_fire;
   logic                    rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]        cnt_q [NUM_REQS];
   logic [CNT_W-1:0]        cnt_d [NUM_REQS];

   logic                    sel_rw;
   logic [BYTEEN_W-1:0]     sel_byteen;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [TAG_IN_WIDTH-1:0] sel_tag;

   logic                     out_valid_q;
   logic                     out_rw_q;
   logic [BYTEEN_W-1:0]      out_byteen_q;
   logic [ADDR_WIDTH-1:0]    out_addr_q;
   logic [DATA_WIDTH-1:0]    out_data_q;
   logic [TAG_OUT_WIDTH-1:0] out_tag_q;

   // Writes bypass the outstanding-read limit since they never produce a response.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         eligible[i] = in_req_valid[i] & (in_req_rw[i] | (cnt_q[i] < CNT_W'(MAX_PENDING)));
      end
   end

   assign rotated = NUM_REQS'({eligible, eligible} >> ptr_q);

   always_comb begin
      int unsigned w;
      grant_found = 1'b0;
      winner      = '0;
      w           = 0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         if (!grant_found && rotated[k]) begin
            grant_found = 1'b1;
            w = 32'(ptr_q) + k;
            if (w >= NUM_REQS) w = w - NUM_REQS;
            winner = SEL_W'(w);
         end
      end
   end

   assign grant        = grant_found ? (NUM_REQS'(1) << winner) : '0;
   assign stage_ready  = ~out_valid_q | mem_req_ready;
   assign accept       = grant_found & stage_ready;
   assign in_req_ready = grant & {NUM_REQS{stage_ready}};

   always_comb begin
      sel_rw     = in_req_rw[0];
      sel_byteen = in_req_byteen[BYTEEN_W-1:0];
      sel_addr   = in_req_addr[ADDR_WIDTH-1:0];
      sel_data   = in_req_data[DATA_WIDTH-1:0];
      sel_tag    = in_req_tag[TAG_IN_WIDTH-1:0];
      for (int unsigned i = 1; i < NUM_REQS; i++) begin
         if (SEL_W'(i) == winner) begin
            sel_rw     = in_req_rw[i];
            sel_byteen = in_req_byteen[i*BYTEEN_W +: BYTEEN_W];
            sel_addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_tag    = in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
         end
      end
   end

   assign ptr_d = !accept ? ptr_q
                : (winner == SEL_W'(NUM_REQS - 1)) ? '0 : winner + SEL_W'(1);

   // Out-of-range selectors only exist for non-power-of-2 NUM_REQS; they are drained and flagged.
   assign rsp_sel = mem_rsp_tag[SEL_W-1:0];

   always_comb begin
      in_rsp_valid  = '0;
      rsp_sel_ok    = 1'b0;
      mem_rsp_ready = 1'b1;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         if (SEL_W'(i) == rsp_sel) begin
            rsp_sel_ok      = 1'b1;
            in_rsp_valid[i] = mem_rsp_valid;
            mem_rsp_ready   = in_rsp_ready[i];
         end
      end
   end

   assign rsp_fire    = in_rsp_valid & in_rsp_ready;
   assign in_rsp_tag  = mem_rsp_tag[TAG_OUT_WIDTH-1:SEL_W];
   assign in_rsp_data = mem_rsp_data;

   always_comb begin
      cnt_zero_fire = 1'b0;
      any_pending   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (in_req_ready[i] & ~in_req_rw[i] & ~rsp_fire[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (~(in_req_ready[i] & ~in_req_rw[i]) & rsp_fire[i] & (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         if (rsp_fire[i] & (cnt_q[i] == '0)) cnt_zero_fire = 1'b1;
         if (cnt_q[i] != '0) any_pending = 1'b1;
      end
   end

   assign rsp_err_d = rsp_err_q | cnt_zero_fire | (mem_rsp_valid & ~rsp_sel_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         rsp_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_rw_q     <= 1'b0;
         out_byteen_q <= '0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_tag_q    <= '0;
         for (int unsigned i = 0; i < NUM_REQS; i++) cnt_q[i] <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rsp_err_q <= rsp_err_d;
         for (int unsigned i = 0; i < NUM_REQS; i++) cnt_q[i] <= cnt_d[i];
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_rw_q     <= sel_rw;
            out_byteen_q <= sel_byteen;
            out_addr_q   <= sel_addr;
            out_data_q   <= sel_data;
            out_tag_q    <= {sel_tag, winner};
         end else if (mem_req_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign mem_req_valid  = out_valid_q;
   assign mem_req_rw     = out_rw_q;
   assign mem_req_byteen = out_byteen_q;
   assign mem_req_addr   = out_addr_q;
   assign mem_req_data   = out_data_q;
   assign mem_req_tag    = out_tag_q;

   assign busy    = out_valid_q | any_pending;
   assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_vx_mem_port_arbiter.sv
// Self-checking bench for vx_mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (grant order, pending counts, held output request).
module tb_vx_mem_port_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   in_req_valid, in_req_rw, in_req_ready;
   logic [255:0] in_req_byteen;
   logic [103:0] in_req_addr;
   logic [2047:0] in_req_data;
   logic [31:0]  in_req_tag;
   logic [3:0]   in_rsp_valid, in_rsp_ready;
   logic [511:0] in_rsp_data;
   logic [7:0]   in_rsp_tag;
   logic         mem_req_valid, mem_req_rw, mem_req_ready;
   logic [63:0]  mem_req_byteen;
   logic [25:0]  mem_req_addr;
   logic [511:0] mem_req_data;
   logic [9:0]   mem_req_tag;
   logic         mem_rsp_valid, mem_rsp_ready;
   logic [511:0] mem_rsp_data;
   logic [9:0]   mem_rsp_tag;
   logic         busy, rsp_err;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int           m_ptr;
   int           m_cnt [4];
   bit           m_err;
   bit           m_ov;
   logic         m_rw;
   logic [63:0]  m_be;
   logic [25:0]  m_addr;
   logic [511:0] m_data;
   logic [9:0]   m_tag;

   vx_mem_port_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .in_req_valid   (in_req_valid),
      .in_req_rw      (in_req_rw),
      .in_req_byteen  (in_req_byteen),
      .in_req_addr    (in_req_addr),
      .in_req_data    (in_req_data),
      .in_req_tag     (in_req_tag),
      .in_req_ready   (in_req_ready),
      .in_rsp_valid   (in_rsp_valid),
      .in_rsp_data    (in_rsp_data),
      .in_rsp_tag     (in_rsp_tag),
      .in_rsp_ready   (in_rsp_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_rw     (mem_req_rw),
      .mem_req_byteen (mem_req_byteen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_tag    (mem_req_tag),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_tag    (mem_rsp_tag),
      .mem_rsp_ready  (mem_rsp_ready),
      .busy           (busy),
      .rsp_err        (rsp_err)
   );

   always #5 clk = ~clk;

   function automatic int m_grant();
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (in_req_valid[2'(i)] && (in_req_rw[2'(i)] || m_cnt[2'(i)] < 16)) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_ptr = 0;
      m_err = 1'b0;
      m_ov  = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[2'(i)] = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic m_step();
      int g;
      int n;
      bit acc;
      bit fire;
      logic [1:0] s;
      g    = m_grant();
      acc  = (g >= 0) && (!m_ov || mem_req_ready);
      s    = mem_rsp_tag[1:0];
      fire = mem_rsp_valid && in_rsp_ready[s];
      for (int i = 0; i < 4; i++) begin
         bit inc;
         bit dec;
         inc = acc && (g == i) && !in_req_rw[2'(i)];
         dec = fire && (s == 2'(i));
         if (dec && m_cnt[2'(i)] == 0) m_err = 1'b1;
         n = m_cnt[2'(i)] + int'(inc) - int'(dec);
         m_cnt[2'(i)] = (n < 0) ? 0 : n;
      end
      if (acc) begin
         m_ov   = 1'b1;
         m_rw   = in_req_rw[2'(g)];
         m_be   = in_req_byteen[g*64 +: 64];
         m_addr = in_req_addr[g*26 +: 26];
         m_data = in_req_data[g*512 +: 512];
         m_tag  = {in_req_tag[g*8 +: 8], 2'(g)};
         m_ptr  = (g + 1) % 4;
      end else if (mem_req_ready) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic cycle();
      m_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      in_req_valid  = '0;
      in_req_rw     = '0;
      in_req_byteen = '0;
      in_req_addr   = '0;
      in_req_data   = '0;
      in_req_tag    = '0;
      in_rsp_ready  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_tag   = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input logic v, input logic rw, input logic [25:0] a,
                          input logic [7:0] t);
      in_req_valid[2'(i)]    = v;
      in_req_rw[2'(i)]       = rw;
      in_req_addr[i*26 +: 26] = a;
      in_req_tag[i*8 +: 8]   = t;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      m_reset();
      @(negedge clk);
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_err: got %b expected 0", rsp_err);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 26'(i), 8'(i));
      mem_req_ready = 1'b1;
      #1;
      checks++;
      if (in_req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_priority: got %b expected 0001", in_req_ready);
      end
      cycle();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag[1:0] !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_grant: got valid=%b sel=%0d expected valid=1 sel=0",
                  mem_req_valid, mem_req_tag[1:0]);
      end
   endtask

   task automatic test_round_robin();
      int e;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 26'(100 + i), 8'h10 + 8'(i));
      mem_req_ready = 1'b1;
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || in_req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rr_start: got valid=%b ready=%b expected valid=0 ready=0001",
                  mem_req_valid, in_req_ready);
      end
      for (int k = 0; k < 9; k++) begin
         cycle();
         e = k % 4;
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_tag !== {8'h10 + 8'(e), 2'(e)} ||
             mem_req_addr !== 26'(100 + e)) begin
            errors++;
            $display("FAIL rr_order[%0d]: got v=%b tag=%h addr=%0d expected v=1 tag=%h addr=%0d",
                     k, mem_req_valid, mem_req_tag, mem_req_addr, {8'h10 + 8'(e), 2'(e)}, 100 + e);
         end
         checks++;
         if (in_req_ready !== (4'b0001 << ((k + 1) % 4))) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_req_ready,
                     4'b0001 << ((k + 1) % 4));
         end
      end
   endtask

   task automatic test_throttle();
      do_reset();
      mem_req_ready = 1'b1;
      set_req(1, 1'b1, 1'b0, 26'h111, 8'h21);
      for (int k = 0; k < 16; k++) begin
         #1;
         checks++;
         if (in_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL throttle_fill[%0d]: got %b expected 0010", k, in_req_ready);
         end
         cycle();
      end
      #1;
      checks++;
      if (in_req_ready !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL throttle_block: got ready=%b busy=%b expected ready=0000 busy=1",
                  in_req_ready, busy);
      end
      set_req(2, 1'b1, 1'b0, 26'h222, 8'h22);
      #1;
      checks++;
      if (in_req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL throttle_other: got %b expected 0100", in_req_ready);
      end
      cycle();
      set_req(2, 1'b0, 1'b0, 26'h222, 8'h22);
      set_req(1, 1'b1, 1'b1, 26'h333, 8'h23);
      #1;
      checks++;
      if (in_req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL throttle_write: got %b expected 0010", in_req_ready);
      end
      cycle();
      set_req(1, 1'b1, 1'b0, 26'h444, 8'h24);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'h3C, 2'd1};
      in_rsp_ready  = 4'b0010;
      #1;
      checks++;
      if (in_rsp_valid !== 4'b0010 || in_req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL throttle_rsp: got rsp_valid=%b ready=%b expected 0010 0000",
                  in_rsp_valid, in_req_ready);
      end
      cycle();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (in_req_ready !== 4'b0010 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL throttle_reenable: got ready=%b err=%b expected 0010 0",
                  in_req_ready, rsp_err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_req_ready = 1'b1;
      set_req(0, 1'b1, 1'b0, 26'h12_3456, 8'h77);
      #1;
      checks++;
      if (in_req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_first: got %b expected 0001", in_req_ready);
      end
      cycle();
      mem_req_ready = 1'b0;
      set_req(0, 1'b1, 1'b0, 26'h0A_BCDE, 8'h78);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 26'h12_3456 ||
             mem_req_tag !== {8'h77, 2'd0} || in_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b addr=%h tag=%h ready=%b expected 1 123456 1dc 0000",
                     k, mem_req_valid, mem_req_addr, mem_req_tag, in_req_ready);
         end
         cycle();
      end
      mem_req_ready = 1'b1;
      #1;
      checks++;
      if (in_req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_release: got %b expected 0001", in_req_ready);
      end
      cycle();
      checks++;
      if (mem_req_addr !== 26'h0A_BCDE || mem_req_tag !== {8'h78, 2'd0}) begin
         errors++;
         $display("FAIL bp_next: got addr=%h tag=%h expected 0abcde 1e0", mem_req_addr, mem_req_tag);
      end
   endtask

   task automatic test_rsp_routing();
      logic [511:0] d;
      do_reset();
      mem_req_ready = 1'b1;
      set_req(2, 1'b1, 1'b0, 26'h55, 8'h31);
      cycle();
      cycle();
      set_req(2, 1'b0, 1'b0, 26'h55, 8'h31);
      cycle();
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'hA5, 2'd2};
      mem_rsp_data  = d;
      in_rsp_ready  = 4'b1011;
      #1;
      checks++;
      if (in_rsp_valid !== 4'b0100 || in_rsp_tag !== 8'hA5 || mem_rsp_ready !== 1'b0) begin
         errors++;
         $display("FAIL rsp_route: got valid=%b tag=%h ready=%b expected 0100 a5 0",
                  in_rsp_valid, in_rsp_tag, mem_rsp_ready);
      end
      checks++;
      if (in_rsp_data !== d) begin
         errors++;
         $display("FAIL rsp_data: got %h expected %h", in_rsp_data[63:0], d[63:0]);
      end
      cycle();
      in_rsp_ready = 4'b0100;
      #1;
      checks++;
      if (busy !== 1'b1 || mem_rsp_ready !== 1'b1) begin
         errors++;
         $display("FAIL rsp_stall_kept: got busy=%b ready=%b expected 1 1", busy, mem_rsp_ready);
      end
      cycle();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rsp_dec_one: got busy=%b expected 1", busy);
      end
      cycle();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL rsp_drained: got busy=%b err=%b expected 0 0", busy, rsp_err);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      mem_req_ready = 1'b1;
      set_req(3, 1'b1, 1'b0, 26'h66, 8'h41);
      repeat (5) cycle();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'h5A, 2'd3};
      in_rsp_ready  = 4'b1000;
      #1;
      checks++;
      if (in_req_ready !== 4'b1000 || mem_rsp_ready !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_fire: got ready=%b rsp_ready=%b expected 1000 1",
                  in_req_ready, mem_rsp_ready);
      end
      cycle();
      set_req(3, 1'b0, 1'b0, 26'h66, 8'h41);
      for (int j = 0; j < 5; j++) begin
         #1;
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_busy[%0d]: got %b expected 1", j, busy);
         end
         cycle();
      end
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_end: got busy=%b err=%b expected 0 0", busy, rsp_err);
      end
   endtask

   task automatic test_rsp_err_and_reset();
      do_reset();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'h01, 2'd0};
      in_rsp_ready  = 4'b0001;
      #1;
      checks++;
      if (rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got %b expected 0", rsp_err);
      end
      cycle();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (rsp_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got %b expected 1", rsp_err);
      end
      repeat (3) cycle();
      checks++;
      if (rsp_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 1", rsp_err);
      end
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 26'(200 + i), 8'(i));
      mem_req_ready = 1'b1;
      repeat (3) cycle();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b busy=%b err=%b expected 0 0 0",
                  mem_req_valid, busy, rsp_err);
      end
      clear_inputs();
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'h02, 2'd1};
      in_rsp_ready  = 4'b0010;
      #1;
      cycle();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (rsp_err !== 1'b1) begin
         errors++;
         $display("FAIL err_after_reset: got %b expected 1", rsp_err);
      end
   endtask

   task automatic test_random();
      int g;
      int s;
      logic [3:0] exp_ready;
      logic [3:0] exp_rsp;
      bit any_cnt;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         in_req_valid = 4'($urandom);
         in_req_rw    = 4'($urandom & $urandom);
         for (int w = 0; w < 64; w++) in_req_data[w*32 +: 32] = $urandom;
         for (int w = 0; w < 8; w++) in_req_byteen[w*32 +: 32] = $urandom;
         for (int i = 0; i < 4; i++) begin
            in_req_addr[i*26 +: 26] = 26'($urandom);
            in_req_tag[i*8 +: 8]    = 8'($urandom);
         end
         mem_req_ready = ($urandom % 4) != 0;
         s = int'($urandom % 4);
         mem_rsp_valid = (m_cnt[2'(s)] > 0) ? ($urandom % 2 == 0) : ($urandom % 20 == 0);
         mem_rsp_tag   = {8'($urandom), 2'(s)};
         for (int w = 0; w < 16; w++) mem_rsp_data[w*32 +: 32] = $urandom;
         in_rsp_ready = 4'($urandom);
         #1;
         g = m_grant();
         exp_ready = (g >= 0 && (!m_ov || mem_req_ready)) ? (4'b0001 << g) : 4'b0000;
         exp_rsp   = mem_rsp_valid ? (4'b0001 << s) : 4'b0000;
         any_cnt   = 1'b0;
         for (int i = 0; i < 4; i++) if (m_cnt[2'(i)] != 0) any_cnt = 1'b1;
         checks++;
         if (in_req_ready !== exp_ready) begin
            errors++;
            $display("FAIL rnd_ready[%0d]: got %b expected %b", c, in_req_ready, exp_ready);
         end
         checks++;
         if (mem_req_valid !== m_ov) begin
            errors++;
            $display("FAIL rnd_valid[%0d]: got %b expected %b", c, mem_req_valid, m_ov);
         end
         if (m_ov) begin
            checks++;
            if ({mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen, mem_req_data} !==
                {m_rw, m_addr, m_tag, m_be, m_data}) begin
               errors++;
               $display("FAIL rnd_stage[%0d]: got rw=%b addr=%h tag=%h be=%h expected rw=%b addr=%h tag=%h be=%h",
                        c, mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen,
                        m_rw, m_addr, m_tag, m_be);
            end
         end
         checks++;
         if (in_rsp_valid !== exp_rsp || mem_rsp_ready !== in_rsp_ready[2'(s)] ||
             in_rsp_tag !== mem_rsp_tag[9:2]) begin
            errors++;
            $display("FAIL rnd_rsp[%0d]: got valid=%b ready=%b tag=%h expected %b %b %h", c,
                     in_rsp_valid, mem_rsp_ready, in_rsp_tag, exp_rsp, in_rsp_ready[2'(s)],
                     mem_rsp_tag[9:2]);
         end
         checks++;
         if (busy !== (m_ov | any_cnt) || rsp_err !== m_err) begin
            errors++;
            $display("FAIL rnd_status[%0d]: got busy=%b err=%b expected %b %b", c, busy, rsp_err,
                     m_ov | any_cnt, m_err);
         end
         cycle();
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_round_robin();
      test_throttle();
      test_backpressure();
      test_rsp_routing();
      test_same_cycle();
      test_rsp_err_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
